// File: rtl/rs_bram_pl_loader.sv
// BRAM preload loader: streams WORD_CNT words into the preload chain starting at BASE_ADDR.
// Define RS_BRAM_PL_LOADER_VERIFY_EN to add per-word readback verify (WPULSE/RDREQ/CMP).
module rs_bram_pl_loader #(
  localparam int unsigned AW = 32,
  localparam int unsigned CW = 16,
  localparam int unsigned DW = 36,
  localparam int unsigned WW = 2
) (
  input  logic          CLK_i,
  input  logic          RESET_N_i,
  input  logic          START_i,
  input  logic          ABORT_i,
  input  logic [0:AW-1] BASE_ADDR_i,
  input  logic [0:CW-1] WORD_CNT_i,
  input  logic          DATA_VALID_i,
  input  logic [0:DW-1] DATA_i,
  output logic          DATA_READY_o,
  input  logic [0:DW-1] PL_RDATA_i,
  output logic          PL_INIT_o,
  output logic          PL_ENA_o,
  output logic          PL_REN_o,
  output logic [0:WW-1] PL_WEN_o,
  output logic [0:AW-1] PL_ADDR_o,
  output logic [0:DW-1] PL_DATA_o,
  output logic          BUSY_o,
  output logic          DONE_o,
  output logic          ERR_o,
  output logic [0:AW-1] ERR_ADDR_o
);

`ifdef RS_BRAM_PL_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, WPULSE, RDREQ, CMP, FLUSH} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, WPULSE, FLUSH} state_t;
`endif

  state_t        state_q, state_d;
  logic [0:AW-1] addr_q, addr_d;
  logic [0:CW-1] cnt_q, cnt_d;
  logic          start_ok, zero_start, abort_ok, hs;

  logic          ready_d, init_d, ena_d, busy_d, done_d;
  logic [0:WW-1] wen_d;
  logic [0:AW-1] pl_addr_d;
  logic [0:DW-1] pl_data_d;

  assign start_ok   = (state_q == IDLE) && START_i;
  assign zero_start = start_ok && (WORD_CNT_i == '0);
  assign abort_ok   = (state_q != IDLE) && ABORT_i;
  // Abort wins over a handshake in the same cycle.
  assign hs         = (state_q == WRITE) && DATA_READY_o && DATA_VALID_i && !abort_ok;

  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (start_ok && !zero_start) state_d = SETUP;
        SETUP:  state_d = WRITE;
`ifdef RS_BRAM_PL_LOADER_VERIFY_EN
        WRITE:  if (hs) state_d = WPULSE;
        WPULSE: state_d = RDREQ;
        RDREQ:  state_d = CMP;
        CMP:    state_d = (cnt_q == '0) ? FLUSH : WRITE;
`else
        WRITE:  if (hs) state_d = (cnt_q == CW'(1)) ? FLUSH : WRITE;
`endif
        FLUSH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values for every registered output plus the address/count datapath.
  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wen_d     = '0;
    pl_addr_d = PL_ADDR_o;
    pl_data_d = PL_DATA_o;
    ready_d   = (state_d == WRITE);
    init_d    = (state_d == SETUP);
    ena_d     = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
    done_d    = zero_start || ((state_q == FLUSH) && !abort_ok);
    if (start_ok) begin
      addr_d = BASE_ADDR_i;
      cnt_d  = WORD_CNT_i;
    end
    if (hs) begin
      wen_d     = 2'b11;
      pl_addr_d = addr_q;
      pl_data_d = DATA_i;
      addr_d    = addr_q + AW'(1);
      cnt_d     = cnt_q - CW'(1);
    end
    if (state_d == IDLE) begin
      pl_addr_d = '0;
      pl_data_d = '0;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      DATA_READY_o <= 1'b0;
      PL_INIT_o    <= 1'b0;
      PL_ENA_o     <= 1'b0;
      PL_WEN_o     <= '0;
      PL_ADDR_o    <= '0;
      PL_DATA_o    <= '0;
      BUSY_o       <= 1'b0;
      DONE_o       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      DATA_READY_o <= ready_d;
      PL_INIT_o    <= init_d;
      PL_ENA_o     <= ena_d;
      PL_WEN_o     <= wen_d;
      PL_ADDR_o    <= pl_addr_d;
      PL_DATA_o    <= pl_data_d;
      BUSY_o       <= busy_d;
      DONE_o       <= done_d;
    end
  end

`ifdef RS_BRAM_PL_LOADER_VERIFY_EN
  logic          ren_d, err_d;
  logic [0:AW-1] err_addr_d;

  // Readback arrives in CMP; PL_DATA_o/PL_ADDR_o still hold the word under test.
  always_comb begin
    ren_d      = (state_d == RDREQ);
    err_d      = ERR_o;
    err_addr_d = ERR_ADDR_o;
    if (start_ok) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if ((state_q == CMP) && !abort_ok && !ERR_o && (PL_RDATA_i != PL_DATA_o)) begin
      err_d      = 1'b1;
      err_addr_d = PL_ADDR_o;
    end
  end

  always_ff @(posedge CLK_i) begin
    if (!RESET_N_i) begin
      PL_REN_o   <= 1'b0;
      ERR_o      <= 1'b0;
      ERR_ADDR_o <= '0;
    end else begin
      PL_REN_o   <= ren_d;
      ERR_o      <= err_d;
      ERR_ADDR_o <= err_addr_d;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^PL_RDATA_i;
  assign PL_REN_o     = 1'b0;
  assign ERR_o        = 1'b0;
  assign ERR_ADDR_o   = '0;
`endif

endmodule

// File: tb/tb_rs_bram_pl_loader.sv
// Directed self-checking bench for rs_bram_pl_loader (burst, wrap, zero count, busy start, abort, reset, verify).
module tb_rs_bram_pl_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, dvalid;
  logic [0:31] base;
  logic [0:15] cnt;
  logic [0:35] din, rdata;
  logic        dready, pl_init, pl_ena, pl_ren, busy, done, err;
  logic [0:1]  pl_wen;
  logic [0:31] pl_addr, err_addr;
  logic [0:35] pl_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rs_bram_pl_loader dut (
    .CLK_i(clk), .RESET_N_i(rst_n), .START_i(start), .ABORT_i(abort),
    .BASE_ADDR_i(base), .WORD_CNT_i(cnt), .DATA_VALID_i(dvalid), .DATA_i(din),
    .DATA_READY_o(dready), .PL_RDATA_i(rdata), .PL_INIT_o(pl_init), .PL_ENA_o(pl_ena),
    .PL_REN_o(pl_ren), .PL_WEN_o(pl_wen), .PL_ADDR_o(pl_addr), .PL_DATA_o(pl_data),
    .BUSY_o(busy), .DONE_o(done), .ERR_o(err), .ERR_ADDR_o(err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] ea;
    logic [35:0] w;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dvalid = 1'b0;
    base = '0; cnt = '0; din = '0; rdata = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(dready), 64'd0);
    chk("rst_ena", 64'(pl_ena), 64'd0);
    chk("rst_init", 64'(pl_init), 64'd0);
    chk("rst_wen", 64'(pl_wen), 64'd0);
    chk("rst_addr", 64'(pl_addr), 64'd0);
    chk("rst_data", 64'(pl_data), 64'd0);
    chk("rst_ren", 64'(pl_ren), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_erraddr", 64'(err_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Burst of 4 at 0x100 with valid held high.
    start = 1'b1; base = 32'h100; cnt = 16'd4; dvalid = 1'b1; din = 36'hA00;
    tick();
    start = 1'b0;
    chk("burst_setup_init", 64'(pl_init), 64'd1);
    chk("burst_setup_ena", 64'(pl_ena), 64'd1);
    chk("burst_setup_busy", 64'(busy), 64'd1);
    chk("burst_setup_ready", 64'(dready), 64'd0);
    chk("burst_setup_wen", 64'(pl_wen), 64'd0);
    tick();
    chk("burst_write_ready", 64'(dready), 64'd1);
    chk("burst_write_init", 64'(pl_init), 64'd0);
    chk("burst_write_wen", 64'(pl_wen), 64'd0);
    for (int i = 0; i < 4; i++) begin
      din = 36'(36'hA00 + i);
      tick();
      chk("burst_wen", 64'(pl_wen), 64'd3);
      chk("burst_addr", 64'(pl_addr), 64'(32'h100 + i));
      chk("burst_data", 64'(pl_data), 64'(36'hA00 + i));
      chk("burst_init_low", 64'(pl_init), 64'd0);
      chk("burst_no_done", 64'(done), 64'd0);
    end
    chk("burst_flush_ready", 64'(dready), 64'd0);
    dvalid = 1'b0;
    tick();
    chk("burst_done", 64'(done), 64'd1);
    chk("burst_done_ena", 64'(pl_ena), 64'd0);
    chk("burst_done_busy", 64'(busy), 64'd0);
    chk("burst_done_wen", 64'(pl_wen), 64'd0);
    tick();
    chk("burst_done_once", 64'(done), 64'd0);

    // Address wrap across 2^32.
    start = 1'b1; base = 32'hFFFF_FFFE; cnt = 16'd3;
    tick();
    start = 1'b0;
    tick();
    ea = 32'hFFFF_FFFE;
    dvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 36'(36'h5_0000_0000 + i);
      tick();
      chk("wrap_wen", 64'(pl_wen), 64'd3);
      chk("wrap_addr", 64'(pl_addr), 64'(ea));
      chk("wrap_data", 64'(pl_data), 64'(36'h5_0000_0000 + i));
      ea = ea + 32'd1;
    end
    dvalid = 1'b0;
    tick();
    chk("wrap_done", 64'(done), 64'd1);
    tick();

    // Zero count: immediate DONE, no PL activity.
    start = 1'b1; base = 32'h777; cnt = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_ena", 64'(pl_ena), 64'd0);
    chk("zero_init", 64'(pl_init), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    tick();
    chk("zero_done_once", 64'(done), 64'd0);
    chk("zero_ena_after", 64'(pl_ena), 64'd0);

    // Second START during a job is ignored; valid outside WRITE consumes nothing.
    start = 1'b1; base = 32'h200; cnt = 16'd2; dvalid = 1'b1; din = 36'hBAD;
    tick();
    start = 1'b0;
    tick();
    chk("busy_wen_before_write", 64'(pl_wen), 64'd0);
    dvalid = 1'b0;
    start = 1'b1; base = 32'h900; cnt = 16'd7;
    tick();
    start = 1'b0;
    chk("busy_start_ignored_busy", 64'(busy), 64'd1);
    chk("busy_start_ignored_init", 64'(pl_init), 64'd0);
    chk("busy_start_ready", 64'(dready), 64'd1);
    dvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 36'(36'hC00 + i);
      tick();
      chk("busy_addr", 64'(pl_addr), 64'(32'h200 + i));
      chk("busy_data", 64'(pl_data), 64'(36'hC00 + i));
    end
    dvalid = 1'b0;
    tick();
    chk("busy_count_kept_done", 64'(done), 64'd1);
    tick();

    // Abort after 2 of 5 words, colliding with a handshake.
    start = 1'b1; base = 32'h300; cnt = 16'd5;
    tick();
    start = 1'b0;
    tick();
    dvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = 36'(36'hD00 + i);
      tick();
      chk("abort_pre_addr", 64'(pl_addr), 64'(32'h300 + i));
    end
    abort = 1'b1; din = 36'hDFF;
    tick();
    abort = 1'b0; dvalid = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wen", 64'(pl_wen), 64'd0);
    chk("abort_ena", 64'(pl_ena), 64'd0);
    chk("abort_ready", 64'(dready), 64'd0);
    chk("abort_addr", 64'(pl_addr), 64'd0);
    chk("abort_no_done", 64'(done), 64'd0);
    tick();
    chk("abort_no_done_later", 64'(done), 64'd0);
    chk("abort_stays_idle", 64'(busy), 64'd0);

    // Reset in the middle of a job.
    start = 1'b1; base = 32'h400; cnt = 16'd4;
    tick();
    start = 1'b0;
    tick();
    dvalid = 1'b1; din = 36'hE00;
    tick();
    chk("midrst_pre_wen", 64'(pl_wen), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ena", 64'(pl_ena), 64'd0);
    chk("midrst_wen", 64'(pl_wen), 64'd0);
    chk("midrst_addr", 64'(pl_addr), 64'd0);
    chk("midrst_data", 64'(pl_data), 64'd0);
    chk("midrst_ready", 64'(dready), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    rst_n = 1'b1; dvalid = 1'b0;
    tick();
    chk("midrst_after_done", 64'(done), 64'd0);
    chk("midrst_after_busy", 64'(busy), 64'd0);

`ifdef RS_BRAM_PL_LOADER_VERIFY_EN
    // Verify: corrupt readback of word 1 at base 0x20.
    start = 1'b1; base = 32'h20; cnt = 16'd3;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("vfy_ready", 64'(dready), 64'd1);
      w = 36'(36'hF00 + i);
      din = w; dvalid = 1'b1;
      tick();
      dvalid = 1'b0;
      chk("vfy_wen", 64'(pl_wen), 64'd3);
      chk("vfy_addr", 64'(pl_addr), 64'(32'h20 + i));
      chk("vfy_ready_low", 64'(dready), 64'd0);
      tick();
      chk("vfy_ren", 64'(pl_ren), 64'd1);
      chk("vfy_ren_addr", 64'(pl_addr), 64'(32'h20 + i));
      rdata = (i == 1) ? (w ^ 36'h1) : w;
      tick();
      chk("vfy_cmp_ren", 64'(pl_ren), 64'd0);
      tick();
    end
    chk("vfy_err", 64'(err), 64'd1);
    chk("vfy_err_addr", 64'(err_addr), 64'h21);
    tick();
    chk("vfy_done", 64'(done), 64'd1);
    chk("vfy_err_held", 64'(err), 64'd1);
    start = 1'b1; cnt = 16'd0;
    tick();
    start = 1'b0;
    chk("vfy_err_clear", 64'(err), 64'd0);
    chk("vfy_erraddr_clear", 64'(err_addr), 64'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
